// File: rtl/vec_result_serializer_if.sv
// Handshake bundle for the vector result serializer: a parallel result
// vector (f1..f4) coming in and a byte stream going out, each with
// valid/ready. Lane values carry signed two's complement data verbatim.
interface vec_result_serializer_if #(
  parameter int W = 8
);
  logic [W-1:0] f1;
  logic [W-1:0] f2;
  logic [W-1:0] f3;
  logic [W-1:0] f4;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;

  // Producer of result vectors / consumer of the byte stream.
  modport master (
    output f1, f2, f3, f4, in_valid, dout_ready,
    input  in_ready, dout, dout_valid, dout_last
  );

  // The serializer itself.
  modport slave (
    input  f1, f2, f3, f4, in_valid, dout_ready,
    output in_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/vec_result_serializer.sv
// Vector result serializer: accepts four W-bit lane results in parallel
// and emits them one beat per cycle, lane 1 first. An active slot holds
// the vector being sent and a pending slot holds the next one, so
// consecutive vectors stream without a gap between lane 4 and lane 1.
module vec_result_serializer #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,          // asynchronous, active low
  vec_result_serializer_if.slave bus,
  output logic                   busy,
  output logic [7:0]             frames_sent
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Lane 0 of every packed vector below is f1 (sent first).
  logic [3:0][W-1:0] lane_in;
  logic [3:0][W-1:0] active_reg;
  logic [3:0][W-1:0] active_next;
  logic [3:0][W-1:0] pend_reg;
  logic [3:0][W-1:0] pend_next;

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] idx_reg;
  logic [1:0] idx_next;
  logic       pend_full_reg;
  logic       pend_full_next;
  logic [7:0] frames_reg;
  logic [7:0] frames_next;

  // Control strobes produced by the FSM and consumed by the lane datapath.
  logic load_active_in;
  logic load_active_pend;
  logic load_pend;

  logic capture;
  logic beat;
  logic last_beat;

  assign lane_in = {bus.f4, bus.f3, bus.f2, bus.f1};

  // Ready only reflects slot occupancy, so upstream never sees a
  // combinational path from its own valid or from the sink's ready.
  assign bus.in_ready = !pend_full_reg;
  assign capture      = bus.in_valid && !pend_full_reg;
  assign beat         = (state_reg == SEND) && bus.dout_ready;
  assign last_beat    = beat && (idx_reg == 2'd3);

  // Next-state and slot-control decode.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    pend_full_next   = pend_full_reg;
    frames_next      = frames_reg;
    load_active_in   = 1'b0;
    load_active_pend = 1'b0;
    load_pend        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (capture) begin
          load_active_in = 1'b1;
          idx_next       = 2'd0;
          state_next     = SEND;
        end
      end

      SEND: begin
        if (beat) begin
          if (idx_reg != 2'd3) begin
            idx_next = idx_reg + 2'd1;
          end else begin
            frames_next = frames_reg + 8'd1;
            if (pend_full_reg) begin
              // Capture is blocked while pend is full, so no conflict here.
              load_active_pend = 1'b1;
              pend_full_next   = 1'b0;
              idx_next         = 2'd0;
            end else if (capture) begin
              // Fresh vector goes straight to active: no bubble, pend stays empty.
              load_active_in = 1'b1;
              idx_next       = 2'd0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        // Any other capture while sending parks the vector in pend.
        if (capture && !last_beat) begin
          load_pend      = 1'b1;
          pend_full_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-lane slot datapath: active reloads from pend or from the inputs,
  // pend reloads only from the inputs.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign active_next[gi] = load_active_pend ? pend_reg[gi] :
                             load_active_in   ? lane_in[gi]  :
                                                active_reg[gi];
    assign pend_next[gi]   = load_pend ? lane_in[gi] : pend_reg[gi];
  end

  // Control and data registers; reset discards both slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      pend_full_reg <= 1'b0;
      frames_reg    <= 8'd0;
      active_reg    <= '0;
      pend_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      pend_full_reg <= pend_full_next;
      frames_reg    <= frames_next;
      active_reg    <= active_next;
      pend_reg      <= pend_next;
    end
  end

  // Output stage: all outputs decode from registers; dout is forced to
  // zero whenever no beat is offered.
  always_comb begin
    bus.dout_valid = (state_reg == SEND);
    bus.dout       = (state_reg == SEND) ? active_reg[idx_reg] : '0;
    bus.dout_last  = (state_reg == SEND) && (idx_reg == 2'd3);
    busy           = (state_reg == SEND) || pend_full_reg;
    frames_sent    = frames_reg;
  end

endmodule

// File: tb/tb_vec_result_serializer.sv
// Bench for vec_result_serializer. The reference model is a byte queue:
// every accepted vector appends its four lanes, every transferred beat pops
// the head. All expected outputs are derived from the queue length.
module tb_vec_result_serializer;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] frames_sent;

  vec_result_serializer_if #(.W(W)) bus ();

  vec_result_serializer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_q[$];
  int         exp_frames = 0;
  int         vec_count  = 0;
  bit         last_cap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every observable output follows from how many bytes remain queued:
  // up to four means one vector in flight, more means pend is occupied.
  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check_val("dout_valid", 32'(bus.dout_valid), 32'(n > 0));
    check_val("dout", 32'(bus.dout), (n > 0) ? 32'(exp_q[0]) : 32'd0);
    check_val("dout_last", 32'(bus.dout_last), 32'((n % 4) == 1));
    check_val("in_ready", 32'(bus.in_ready), 32'(n <= 4));
    check_val("busy", 32'(busy), 32'(n > 0));
    check_val("frames_sent", 32'(frames_sent), 32'(exp_frames % 256));
  endtask

  // One clock cycle: drive, check, advance the model, clock.
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input bit r);
    int n;
    bus.in_valid   = v;
    bus.f1         = a;
    bus.f2         = b;
    bus.f3         = c;
    bus.f4         = d;
    bus.dout_ready = r;
    #1;
    check_outputs();
    n        = exp_q.size();
    last_cap = v && (n <= 4);
    if (n > 0 && r) begin
      if ((n % 4) == 1) exp_frames++;
      void'(exp_q.pop_front());
    end
    if (last_cap) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
      vec_count++;
      $display("capture vec %0d: %02h %02h %02h %02h", vec_count, a, b, c, d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input bit r);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, r);
  endtask

  // Asynchronous reset taken between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    #1;
    check_outputs();
    @(negedge clk);
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen255;
    rst            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.f1         = '0;
    bus.f2         = '0;
    bus.f3         = '0;
    bus.f4         = '0;
    bus.dout_ready = 1'b0;
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single vector with sign-boundary lane values.
    step(1'b1, 8'h01, 8'hFE, 8'h7F, 8'h80, 1'b1);
    idle(5, 1'b1);
    check_val("single_frames", 32'(frames_sent), 32'd1);
    check_val("single_idle", 32'(busy), 32'd0);

    // Backpressure on lane 2 for three cycles.
    step(1'b1, 8'h31, 8'h32, 8'h33, 8'h34, 1'b1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    idle(3, 1'b0);
    check_val("bp_hold_lane2", 32'(bus.dout), 32'h32);
    idle(5, 1'b1);

    // Back-to-back: B offered while A drains.
    step(1'b1, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1);
    step(1'b1, 8'd20, 8'd21, 8'd22, 8'd23, 1'b1);
    idle(9, 1'b1);
    check_val("b2b_frames", 32'(frames_sent), 32'd4);

    // Pending full: third vector refused until pend drains into active.
    step(1'b1, 8'h41, 8'h42, 8'h43, 8'h44, 1'b0);
    step(1'b1, 8'h51, 8'h52, 8'h53, 8'h54, 1'b0);
    step(1'b1, 8'h61, 8'h62, 8'h63, 8'h64, 1'b0);
    check_val("pend_refuse", 32'(last_cap), 32'd0);
    check_val("pend_in_ready", 32'(bus.in_ready), 32'd0);
    last_cap = 1'b0;
    for (int i = 0; i < 20 && !last_cap; i++) step(1'b1, 8'h61, 8'h62, 8'h63, 8'h64, 1'b1);
    check_val("third_accepted", 32'(last_cap), 32'd1);
    idle(14, 1'b1);

    // Reset after lane 2 is on the bus, then a fresh vector.
    step(1'b1, 8'h71, 8'h72, 8'h73, 8'h74, 1'b1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    check_val("pre_reset_lane2", 32'(bus.dout), 32'h72);
    do_reset();
    step(1'b1, 8'h81, 8'h82, 8'h83, 8'h84, 1'b1);
    check_val("post_reset_lane1", 32'(bus.dout), 32'h81);
    idle(6, 1'b1);
    check_val("post_reset_frames", 32'(frames_sent), 32'd1);

    // Counter wrap over 256 streamed vectors.
    do_reset();
    seen255 = 1'b0;
    for (int v = 0; v < 256; ) begin
      logic [7:0] base;
      base = 8'(v);
      step(1'b1, base, base ^ 8'h55, base ^ 8'hAA, ~base, 1'b1);
      if (last_cap) v++;
      if (!seen255 && exp_frames == 255) begin
        seen255 = 1'b1;
        check_val("wrap_255", 32'(frames_sent), 32'd255);
      end
    end
    idle(12, 1'b1);
    check_val("wrap_0", 32'(frames_sent), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 40), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom_range(0, 99) < 70));
    end
    idle(12, 1'b1);
    check_val("drain_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
